pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Next-PC controller for the RV64I core. Each cycle it decides whether the PC register is written and with what value. Sources are the sequential +4 path, branch/jump redirect, trap entry and mret return. Redirects arriving during a stall are buffered and applied when the stall releases. The block drives the PC register's write-enable and data inputs and raises the pipeline flush.

Parameters:
BOOT_ADDR, 64'h80000000, first PC written after reset
XLEN, 64, address width

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
pc_i  input  XLEN  current PC from the PC register
stall_i  input  1  pipeline stall; PC must hold
halt_i  input  1  enter halt (ecall/ebreak stop)
branch_valid_i  input  1  taken branch/jump this cycle
branch_target_i  input  XLEN  branch/jump target
trap_valid_i  input  1  exception/interrupt entry
trap_vec_i  input  XLEN  mtvec value
mret_valid_i  input  1  mret executed
mepc_i  input  XLEN  return address
pc_we_o  output  1  PC write enable
pc_next_o  output  XLEN  PC write data
flush_o  output  1  flush fetch/decode; high with any applied redirect
misalign_o  output  1  one-cycle pulse: misaligned redirect replaced by trap_vec_i
pending_o  output  1  redirect buffered during stall
state_o  output  2  0 BOOT, 1 RUN, 2 STALL, 3 HALT
redirect_cnt_o  output  32  applied-redirect counter, saturating

Behaviour:
- Reset (async, rst_ni=0): state=BOOT; pend_valid=0; misalign_o=0; redirect_cnt_o=0. Combinational outputs in BOOT: pc_we_o=1, pc_next_o=BOOT_ADDR, flush_o=0.
- Redirect priority: trap > mret > branch. Targets:
  - trap: trap_vec_i with bits[1:0] forced to 0.
  - mret: mepc_i.
  - branch: branch_target_i.
- Misalign rule: if a selected mret or branch target has bits[1:0]!=0, the applied target is trap_vec_i&~3. misalign_o pulses high in the cycle after the write.
- Sequential path: pc_i+4, wrapping modulo 2^64. 64'hFFFFFFFFFFFFFFFC goes to 0.
- pc_we_o, pc_next_o and flush_o are combinational from state, pending register and inputs. Zero latency: the PC register updates at the same clock edge.
- BOOT: pc_we_o=1, pc_next_o=BOOT_ADDR; all inputs ignored. Next state RUN.
- RUN:
  - halt_i=1 (highest precedence; redirects that cycle are dropped): pc_we_o=0, next state HALT.
  - stall_i=1: pc_we_o=0, flush_o=0. Any redirect is captured into the pending register (priority, target, misalign flag). Next state STALL.
  - Otherwise: pc_we_o=1. With a redirect, pc_next_o=target and flush_o=1. Without one, pc_next_o=pc_i+4.
- STALL:
  - pc_we_o=0 while stall_i=1. A new redirect replaces the pending one only if its priority is greater than or equal to the pending priority.
  - When stall_i=0, the winner of pending and same-cycle redirect is chosen by the same rule. pc_we_o=1.
  - If there is a winner: pc_next_o=its target, flush_o=1, pending cleared. Otherwise pc_next_o=pc_i+4.
  - Next state RUN. halt_i is ignored in STALL.
- pending_o = pend_valid (registered).
- HALT: pc_we_o=0, flush_o=0. Only trap_valid_i exits: pc_we_o=1, pc_next_o=trap_vec_i&~3, flush_o=1, next state RUN. mret and branch are ignored.
- redirect_cnt_o increments by 1 on every cycle with pc_we_o&flush_o, saturating at 32'hFFFFFFFF.
- Reset asserted mid-stall discards the pending redirect. The first post-reset write is BOOT_ADDR.

Test Plan:
1. Release reset, no inputs → cycle 0: pc_we_o=1, pc_next_o=0x80000000. Then with pc_i tracking: 0x80000004, 0x80000008; state_o=1.
2. RUN, pc_i=0x80000010, branch_valid_i=1, branch_target_i=0x80000100, trap_valid_i=1, trap_vec_i=0x80000203 → pc_next_o=0x80000200, flush_o=1, redirect_cnt_o=1 next cycle.
3. stall_i=1 for 3 cycles, branch to 0x80000040 in cycle 1, mret (mepc_i=0x80000080) in cycle 2 → pc_we_o=0 and pending_o=1 throughout the stall. On release: pc_next_o=0x80000080, flush_o=1, pending_o=0.
4. RUN, branch_target_i=0x80000042, trap_vec_i=0x80000300 → pc_next_o=0x80000300, misalign_o=1 for exactly one cycle after the write.
5. halt_i=1 → state_o=3, pc_we_o=0 for 5 cycles despite branch_valid_i=1. Then trap_valid_i=1 with trap_vec_i=0x80000500 → pc_next_o=0x80000500, state_o=1.
6. pc_i=64'hFFFFFFFFFFFFFFFC, no redirect → pc_next_o=0. Separately, rst_ni dropped while pending_o=1 → all outputs reset immediately and the next write is 0x80000000.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Signal bundle between the next-PC controller and the core: PC feedback,
// redirect requests, stall/halt control and the PC-register write port.
interface pc_sequencer_if #(
   parameter int XLEN = 64
);
   logic [XLEN-1:0] pc_i;
   logic            stall_i;
   logic            halt_i;
   logic            branch_valid_i;
   logic [XLEN-1:0] branch_target_i;
   logic            trap_valid_i;
   logic [XLEN-1:0] trap_vec_i;
   logic            mret_valid_i;
   logic [XLEN-1:0] mepc_i;
   logic            pc_we_o;
   logic [XLEN-1:0] pc_next_o;
   logic            flush_o;
   logic            misalign_o;
   logic            pending_o;
   logic [1:0]      state_o;
   logic [31:0]     redirect_cnt_o;

   // Core side: drives requests and observes the PC write port.
   modport master (
      output pc_i, stall_i, halt_i, branch_valid_i, branch_target_i,
             trap_valid_i, trap_vec_i, mret_valid_i, mepc_i,
      input  pc_we_o, pc_next_o, flush_o, misalign_o, pending_o,
             state_o, redirect_cnt_o
   );

   // Sequencer side.
   modport slave (
      input  pc_i, stall_i, halt_i, branch_valid_i, branch_target_i,
             trap_valid_i, trap_vec_i, mret_valid_i, mepc_i,
      output pc_we_o, pc_next_o, flush_o, misalign_o, pending_o,
             state_o, redirect_cnt_o
   );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: picks between boot address, sequential +4, trap, mret
// and branch redirects; buffers redirects that arrive while the pipe stalls.
module pc_sequencer #(
   parameter int              XLEN      = 64,
   parameter logic [XLEN-1:0] BOOT_ADDR = XLEN'(64'h8000_0000)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   pc_sequencer_if.slave      bus
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   localparam logic [1:0] PRIO_BRANCH = 2'd1;
   localparam logic [1:0] PRIO_MRET   = 2'd2;
   localparam logic [1:0] PRIO_TRAP   = 2'd3;

   typedef struct packed {
      logic            valid;
      logic [1:0]      prio;
      logic [XLEN-1:0] target;
      logic            mis;
   } redir_t;

   state_e          state_q, state_d;
   redir_t          pend_q, pend_d;
   redir_t          cur;
   logic            misalign_q, misalign_d;
   logic [31:0]     cnt_q, cnt_d;

   logic            pc_we;
   logic [XLEN-1:0] pc_next;
   logic            flush;
   logic            applied_mis;
   logic            cur_wins;
   logic [XLEN-1:0] trap_aligned;

   assign trap_aligned = {bus.trap_vec_i[XLEN-1:2], 2'b00};

   // Resolve this cycle's request; a misaligned mret/branch target is
   // replaced by the trap vector and remembered so misalign_o can fire.
   always_comb begin
      cur = '0;
      if (bus.trap_valid_i) begin
         cur.valid  = 1'b1;
         cur.prio   = PRIO_TRAP;
         cur.target = trap_aligned;
      end else if (bus.mret_valid_i) begin
         cur.valid  = 1'b1;
         cur.prio   = PRIO_MRET;
         cur.mis    = |bus.mepc_i[1:0];
         cur.target = cur.mis ? trap_aligned : bus.mepc_i;
      end else if (bus.branch_valid_i) begin
         cur.valid  = 1'b1;
         cur.prio   = PRIO_BRANCH;
         cur.mis    = |bus.branch_target_i[1:0];
         cur.target = cur.mis ? trap_aligned : bus.branch_target_i;
      end
   end

   // Ties go to the newer request.
   assign cur_wins = cur.valid && (!pend_q.valid || (cur.prio >= pend_q.prio));

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_d     = state_q;
      pend_d      = pend_q;
      pc_we       = 1'b0;
      pc_next     = bus.pc_i + XLEN'(4);
      flush       = 1'b0;
      applied_mis = 1'b0;

      unique case (state_q)
         ST_BOOT: begin
            pc_we   = 1'b1;
            pc_next = BOOT_ADDR;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.halt_i) begin
               state_d = ST_HALT;
            end else if (bus.stall_i) begin
               pend_d  = cur;
               state_d = ST_STALL;
            end else begin
               pc_we = 1'b1;
               if (cur.valid) begin
                  pc_next     = cur.target;
                  flush       = 1'b1;
                  applied_mis = cur.mis;
               end
            end
         end
         ST_STALL: begin
            if (bus.stall_i) begin
               if (cur_wins) pend_d = cur;
            end else begin
               pc_we   = 1'b1;
               pend_d  = '0;
               state_d = ST_RUN;
               if (cur_wins) begin
                  pc_next     = cur.target;
                  flush       = 1'b1;
                  applied_mis = cur.mis;
               end else if (pend_q.valid) begin
                  pc_next     = pend_q.target;
                  flush       = 1'b1;
                  applied_mis = pend_q.mis;
               end
            end
         end
         ST_HALT: begin
            if (bus.trap_valid_i) begin
               pc_we   = 1'b1;
               pc_next = trap_aligned;
               flush   = 1'b1;
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_BOOT;
      endcase

      misalign_d = pc_we & applied_mis;
      cnt_d      = cnt_q;
      if (pc_we && flush && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_BOOT;
         pend_q     <= '0;
         misalign_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         misalign_q <= misalign_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.pc_we_o        = pc_we;
   assign bus.pc_next_o      = pc_next;
   assign bus.flush_o        = flush;
   assign bus.misalign_o     = misalign_q;
   assign bus.pending_o      = pend_q.valid;
   assign bus.state_o        = state_q;
   assign bus.redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plan steps plus a randomized phase, all scored against a
// behavioural model of the next-PC rules.
module tb_pc_sequencer;

   localparam logic [63:0] BOOT = 64'h8000_0000;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   pc_sequencer_if #(.XLEN(64)) bus ();

   pc_sequencer #(.XLEN(64), .BOOT_ADDR(BOOT)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit          has;
      int          rank;
      logic [63:0] addr;
      bit          bad;
   } req_t;

   // Model state, kept as independent flags rather than a state code.
   bit          m_boot, m_halted, m_stalled, m_mis;
   req_t        m_pend;
   logic [63:0] m_cnt;
   logic [63:0] pc_reg;

   // Values predicted for the current cycle and the model's next state.
   bit          e_we, e_flush, e_bad;
   logic [63:0] e_next;
   bit          n_boot, n_halted, n_stalled;
   req_t        n_pend;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic req_t request();
      req_t r;
      logic [63:0] tv;
      tv = bus.trap_vec_i - (bus.trap_vec_i % 64'd4);
      r = '{has: 1'b0, rank: 0, addr: 64'd0, bad: 1'b0};
      if (bus.trap_valid_i) begin
         r = '{has: 1'b1, rank: 3, addr: tv, bad: 1'b0};
      end else if (bus.mret_valid_i) begin
         r.has = 1'b1; r.rank = 2;
         r.bad = (bus.mepc_i % 64'd4) != 0;
         r.addr = r.bad ? tv : bus.mepc_i;
      end else if (bus.branch_valid_i) begin
         r.has = 1'b1; r.rank = 1;
         r.bad = (bus.branch_target_i % 64'd4) != 0;
         r.addr = r.bad ? tv : bus.branch_target_i;
      end
      return r;
   endfunction

   task automatic apply(input req_t w);
      if (w.has) begin
         e_next = w.addr; e_flush = 1'b1; e_bad = w.bad;
      end else begin
         e_next = pc_reg + 64'd4;
      end
   endtask

   task automatic model_eval();
      req_t r;
      bit   newer;
      r = request();
      newer = r.has && (!m_pend.has || r.rank >= m_pend.rank);
      e_we = 1'b0; e_flush = 1'b0; e_bad = 1'b0; e_next = pc_reg + 64'd4;
      n_boot = m_boot; n_halted = m_halted; n_stalled = m_stalled; n_pend = m_pend;
      if (m_boot) begin
         e_we = 1'b1; e_next = BOOT; n_boot = 1'b0;
      end else if (m_halted) begin
         if (bus.trap_valid_i) begin
            e_we = 1'b1; e_next = r.addr; e_flush = 1'b1; n_halted = 1'b0;
         end
      end else if (m_stalled) begin
         if (bus.stall_i) begin
            if (newer) n_pend = r;
         end else begin
            e_we = 1'b1; n_stalled = 1'b0; n_pend.has = 1'b0;
            apply(newer ? r : m_pend);
         end
      end else begin
         if (bus.halt_i) n_halted = 1'b1;
         else if (bus.stall_i) begin
            n_stalled = 1'b1; n_pend = r;
         end else begin
            e_we = 1'b1;
            apply(r);
         end
      end
   endtask

   task automatic model_commit();
      m_boot = n_boot; m_halted = n_halted; m_stalled = n_stalled; m_pend = n_pend;
      m_mis = e_we && e_flush && e_bad;
      if (e_we && e_flush && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 64'd1;
      if (e_we) pc_reg = e_next;
   endtask

   task automatic model_reset();
      m_boot = 1'b1; m_halted = 1'b0; m_stalled = 1'b0; m_mis = 1'b0;
      m_pend = '{has: 1'b0, rank: 0, addr: 64'd0, bad: 1'b0};
      m_cnt = 64'd0;
   endtask

   function automatic logic [1:0] exp_state();
      if (m_boot)    return 2'd0;
      if (m_halted)  return 2'd3;
      if (m_stalled) return 2'd2;
      return 2'd1;
   endfunction

   // Evaluate the model, then compare every output at the falling edge.
   task automatic sample();
      model_eval();
      @(negedge clk);
      check("pc_we", 64'(bus.pc_we_o), 64'(e_we));
      if (e_we) check("pc_next", bus.pc_next_o, e_next);
      check("flush", 64'(bus.flush_o), 64'(e_flush));
      check("state", 64'(bus.state_o), 64'(exp_state()));
      check("pending", 64'(bus.pending_o), 64'(m_pend.has));
      check("misalign", 64'(bus.misalign_o), 64'(m_mis));
      check("redirect_cnt", 64'(bus.redirect_cnt_o), m_cnt);
   endtask

   task automatic advance();
      @(posedge clk);
      model_commit();
      #1;
      bus.pc_i = pc_reg;
   endtask

   task automatic idle_inputs();
      bus.stall_i = 1'b0; bus.halt_i = 1'b0;
      bus.branch_valid_i = 1'b0; bus.trap_valid_i = 1'b0; bus.mret_valid_i = 1'b0;
   endtask

   function automatic logic [63:0] rand_addr();
      logic [63:0] a;
      a = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 4) == 0) a = a | 64'($urandom_range(1, 3));
      return a;
   endfunction

   initial begin
      tests = 0; fails = 0;
      idle_inputs();
      bus.branch_target_i = '0; bus.trap_vec_i = '0; bus.mepc_i = '0;
      pc_reg = 64'd0; bus.pc_i = pc_reg;
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Step 1: boot write, then sequential +4.
      sample();
      check("boot_addr", bus.pc_next_o, 64'h8000_0000);
      advance();
      sample();
      check("seq_plus4", bus.pc_next_o, 64'h8000_0004);
      advance();
      sample();
      check("seq_plus8", bus.pc_next_o, 64'h8000_0008);
      check("run_state", 64'(bus.state_o), 64'd1);
      advance();

      // Step 2: trap beats branch; trap vector low bits dropped.
      pc_reg = 64'h8000_0010; bus.pc_i = pc_reg;
      bus.branch_valid_i = 1'b1; bus.branch_target_i = 64'h8000_0100;
      bus.trap_valid_i = 1'b1; bus.trap_vec_i = 64'h8000_0203;
      sample();
      check("trap_over_branch", bus.pc_next_o, 64'h8000_0200);
      advance();
      idle_inputs();
      sample();
      check("cnt_after_trap", 64'(bus.redirect_cnt_o), 64'd1);
      advance();

      // Step 3: three-cycle stall, branch then higher-priority mret.
      bus.stall_i = 1'b1; bus.branch_valid_i = 1'b1; bus.branch_target_i = 64'h8000_0040;
      sample(); advance();
      bus.branch_valid_i = 1'b0; bus.mret_valid_i = 1'b1; bus.mepc_i = 64'h8000_0080;
      sample(); advance();
      bus.mret_valid_i = 1'b0;
      sample();
      check("stall_pending", 64'(bus.pending_o), 64'd1);
      advance();
      bus.stall_i = 1'b0;
      sample();
      check("stall_release", bus.pc_next_o, 64'h8000_0080);
      advance();
      sample();
      check("pending_cleared", 64'(bus.pending_o), 64'd0);
      advance();

      // Step 4: misaligned branch replaced by trap vector.
      bus.branch_valid_i = 1'b1; bus.branch_target_i = 64'h8000_0042; bus.trap_vec_i = 64'h8000_0300;
      sample();
      check("misalign_target", bus.pc_next_o, 64'h8000_0300);
      advance();
      bus.branch_valid_i = 1'b0;
      sample();
      check("misalign_pulse", 64'(bus.misalign_o), 64'd1);
      advance();
      sample(); advance();

      // Step 5: halt ignores branches; only a trap exits.
      bus.halt_i = 1'b1;
      sample(); advance();
      bus.halt_i = 1'b0; bus.branch_valid_i = 1'b1; bus.branch_target_i = 64'h8000_0600;
      for (int i = 0; i < 5; i++) begin
         sample();
         check("halt_hold", 64'(bus.state_o), 64'd3);
         advance();
      end
      bus.branch_valid_i = 1'b0; bus.trap_valid_i = 1'b1; bus.trap_vec_i = 64'h8000_0500;
      sample();
      check("halt_exit", bus.pc_next_o, 64'h8000_0500);
      advance();
      bus.trap_valid_i = 1'b0;
      sample();
      check("halt_exit_state", 64'(bus.state_o), 64'd1);
      advance();

      // Step 6: PC wrap, then reset while a redirect is pending.
      pc_reg = 64'hFFFF_FFFF_FFFF_FFFC; bus.pc_i = pc_reg;
      sample();
      check("pc_wrap", bus.pc_next_o, 64'd0);
      advance();
      bus.stall_i = 1'b1; bus.branch_valid_i = 1'b1; bus.branch_target_i = 64'h8000_0700;
      sample(); advance();
      bus.branch_valid_i = 1'b0;
      sample();
      check("pre_reset_pending", 64'(bus.pending_o), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_pending", 64'(bus.pending_o), 64'd0);
      check("rst_state", 64'(bus.state_o), 64'd0);
      check("rst_cnt", 64'(bus.redirect_cnt_o), 64'd0);
      check("rst_misalign", 64'(bus.misalign_o), 64'd0);
      check("rst_pc_next", bus.pc_next_o, BOOT);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_inputs();
      sample();
      check("post_reset_boot", bus.pc_next_o, 64'h8000_0000);
      advance();

      // Randomized phase against the model.
      for (int i = 0; i < 400; i++) begin
         bus.stall_i        = ($urandom_range(0, 9) < 3);
         bus.halt_i         = ($urandom_range(0, 39) == 0);
         bus.trap_valid_i   = ($urandom_range(0, 9) == 0);
         bus.mret_valid_i   = ($urandom_range(0, 6) == 0);
         bus.branch_valid_i = ($urandom_range(0, 3) == 0);
         bus.trap_vec_i      = {$urandom, $urandom};
         bus.mepc_i          = rand_addr();
         bus.branch_target_i = rand_addr();
         sample();
         advance();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
